// File: rtl/hbmc_wdata_ctrl_if.sv
// Bundles the write-command, W-channel, FIFO write and completion signals.
// hbmc_wdata_ctrl uses the slave modport; whatever drives it uses the master modport.
interface hbmc_wdata_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [DATA_WIDTH-1:0]   fifo_wr_din;
  logic [DATA_WIDTH/8-1:0] fifo_wr_strb;
  logic                    fifo_wr_ena;
  logic                    fifo_wr_full;
  logic                    done_valid;
  logic                    done_ready;
  logic                    done_err;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_len, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
           s_axi_wvalid, fifo_wr_full, done_ready,
    output cmd_ready, s_axi_wready, fifo_wr_din, fifo_wr_strb, fifo_wr_ena,
           done_valid, done_err, busy
  );

  modport master (
    output cmd_valid, cmd_len, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
           s_axi_wvalid, fifo_wr_full, done_ready,
    input  cmd_ready, s_axi_wready, fifo_wr_din, fifo_wr_strb, fifo_wr_ena,
           done_valid, done_err, busy
  );
endinterface

// File: rtl/hbmc_wdata_ctrl.sv
// Write-data sequencer: moves cmd_len+1 W beats into the write FIFO, stalls on
// FIFO full, checks WLAST framing and reports per-burst completion.
module hbmc_wdata_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  hbmc_wdata_ctrl_if.slave      bus
);

  if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("hbmc_wdata_ctrl: DATA_WIDTH must be 16, 32 or 64");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [LEN_WIDTH-1:0] w_remaining_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 w_beat;

  // No skid buffer: a full FIFO blocks the handshake in the same cycle.
  assign w_beat = (r_state == S_DATA) && bus.s_axi_wvalid && !bus.fifo_wr_full;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Burst length follows the counter alone; WLAST only feeds the error flag.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_err_nxt       = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_remaining_nxt = bus.cmd_len;
          w_err_nxt       = 1'b0;
          w_state_nxt     = S_DATA;
        end
      end
      S_DATA: begin
        if (w_beat) begin
          if (r_remaining != '0) begin
            w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
            if (bus.s_axi_wlast) w_err_nxt = 1'b1;
          end else begin
            if (!bus.s_axi_wlast) w_err_nxt = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.done_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Every output is forced low while reset is held.
  assign bus.cmd_ready    = s_axi_aresetn && (r_state == S_IDLE);
  assign bus.s_axi_wready = s_axi_aresetn && (r_state == S_DATA) && !bus.fifo_wr_full;
  assign bus.fifo_wr_ena  = s_axi_aresetn && w_beat;
  assign bus.fifo_wr_din  = s_axi_aresetn ? bus.s_axi_wdata : '0;
  assign bus.fifo_wr_strb = s_axi_aresetn ? bus.s_axi_wstrb : '0;
  assign bus.done_valid   = s_axi_aresetn && (r_state == S_RESP);
  assign bus.done_err     = s_axi_aresetn && (r_state == S_RESP) && r_err;
  assign bus.busy         = s_axi_aresetn && (r_state != S_IDLE);

endmodule

// File: tb/tb_hbmc_wdata_ctrl.sv
// Table-driven cycle-by-cycle checks of hbmc_wdata_ctrl, plus a hand-written
// maximum-length burst with random FIFO-full backpressure.
module tb_hbmc_wdata_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hbmc_wdata_ctrl_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

  hbmc_wdata_ctrl #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rstn),
    .bus           (bus)
  );

  typedef struct {
    logic        rstn;
    logic        cv;
    logic [7:0]  len;
    logic        wv;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        wl;
    logic        full;
    logic        dr;
    logic        e_cr;
    logic        e_wr;
    logic        e_ena;
    logic        e_dv;
    logic        e_de;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(logic r, logic cv, logic [7:0] len, logic wv,
                             logic [31:0] wd, logic [3:0] ws, logic wl,
                             logic full, logic dr, logic e_cr, logic e_wr,
                             logic e_ena, logic e_dv, logic e_de, logic e_busy);
    vec_t t;
    t.rstn = r;   t.cv = cv;     t.len = len;   t.wv = wv;     t.wd = wd;
    t.ws = ws;    t.wl = wl;     t.full = full; t.dr = dr;
    t.e_cr = e_cr; t.e_wr = e_wr; t.e_ena = e_ena;
    t.e_dv = e_dv; t.e_de = e_de; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rstn                 = t.rstn;
    bus.cmd_valid        = t.cv;
    bus.cmd_len          = t.len;
    bus.s_axi_wvalid     = t.wv;
    bus.s_axi_wdata      = t.wd;
    bus.s_axi_wstrb      = t.ws;
    bus.s_axi_wlast      = t.wl;
    bus.fifo_wr_full     = t.full;
    bus.done_ready       = t.dr;
  endtask

  initial begin
    // cols: rstn cv len wv wd ws wl full dr | cr wr ena dv de busy
    // reset, with a command and a beat offered: everything gated low
    tbl.push_back(V(0,1,8'd0,1,32'h1111_1111,4'hF,1,0,1, 0,0,0,0,0,0));
    tbl.push_back(V(0,1,8'd0,1,32'h2222_2222,4'h3,1,0,1, 0,0,0,0,0,0));
    // first cycle after release: idle, wready low even with wvalid
    tbl.push_back(V(1,0,8'd0,1,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    // single beat
    tbl.push_back(V(1,1,8'd0,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'hDEAD_BEEF,4'hF,1,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,0, 0,0,0,1,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    // early WLAST, len 3
    tbl.push_back(V(1,1,8'd3,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'h10,4'h1,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h11,4'h2,1,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h12,4'h4,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h13,4'h8,1,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,1,1));
    // missing WLAST, len 1
    tbl.push_back(V(1,1,8'd1,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'h20,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h21,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,1,1));
    // following clean burst, len 1
    tbl.push_back(V(1,1,8'd1,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'h30,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h31,4'hF,1,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,0,1));
    // full stall, len 3: full high in DATA cycles 2..4
    tbl.push_back(V(1,1,8'd3,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'h0,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h1,4'hF,0,1,0, 0,0,0,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h1,4'hF,0,1,0, 0,0,0,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h1,4'hF,0,1,0, 0,0,0,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h1,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h2,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h3,4'hF,1,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,0,1));
    // completion backpressure, len 0, with a gap cycle in DATA
    tbl.push_back(V(1,1,8'd0,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,0, 0,1,0,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h40,4'hF,1,0,0, 0,1,1,0,0,1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(V(1,1,8'd0,1,32'h41,4'hF,1,0,0, 0,0,0,1,0,1));
    tbl.push_back(V(1,1,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,0,1));
    tbl.push_back(V(1,1,8'd0,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'h50,4'hF,1,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,0,1));
    // reset mid-burst, len 7, after 3 beats
    tbl.push_back(V(1,1,8'd7,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'h60,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h61,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,1,32'h62,4'hF,0,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(0,0,8'd0,1,32'h63,4'hF,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(V(0,0,8'd0,1,32'h64,4'hF,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 1,0,0,0,0,0));
    tbl.push_back(V(1,1,8'd0,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(V(1,0,8'd0,1,32'h70,4'h5,1,0,0, 0,1,1,0,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,1, 0,0,0,1,0,1));
    tbl.push_back(V(1,0,8'd0,0,32'h0,4'h0,0,0,0, 1,0,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #4;
      chk($sformatf("v%0d cmd_ready", i),  32'(bus.cmd_ready),    32'(tbl[i].e_cr));
      chk($sformatf("v%0d wready", i),     32'(bus.s_axi_wready), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d wr_ena", i),     32'(bus.fifo_wr_ena),  32'(tbl[i].e_ena));
      chk($sformatf("v%0d done_valid", i), 32'(bus.done_valid),   32'(tbl[i].e_dv));
      chk($sformatf("v%0d done_err", i),   32'(bus.done_err),     32'(tbl[i].e_de));
      chk($sformatf("v%0d busy", i),       32'(bus.busy),         32'(tbl[i].e_busy));
      chk($sformatf("v%0d wr_din", i),     bus.fifo_wr_din,
          tbl[i].rstn ? tbl[i].wd : 32'h0);
      chk($sformatf("v%0d wr_strb", i),    32'(bus.fifo_wr_strb),
          32'(tbl[i].rstn ? tbl[i].ws : 4'h0));
      @(posedge clk);
      #1;
    end

    // maximum length burst: cmd_len 255 -> 256 beats, random FIFO full
    begin
      int   beats     = 0;
      int   order_bad = 0;
      int   full_bad  = 0;
      logic got_done  = 1'b0;
      logic got_err   = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd255; bus.s_axi_wvalid = 1'b0;
      bus.fifo_wr_full = 1'b0; bus.done_ready = 1'b0; bus.s_axi_wlast = 1'b0;
      #4;
      chk("max cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
        bus.fifo_wr_full = ($urandom_range(0, 3) == 0);
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wdata  = 32'hA500_0000 + 32'(beats);
        bus.s_axi_wstrb  = 4'hF;
        bus.s_axi_wlast  = (beats == 255);
        #4;
        if (bus.s_axi_wready && bus.fifo_wr_full) full_bad++;
        if (bus.fifo_wr_ena) begin
          if (bus.fifo_wr_din !== 32'hA500_0000 + 32'(beats)) order_bad++;
          beats++;
        end
        if (bus.done_valid) begin
          got_done = 1'b1;
          got_err  = bus.done_err;
        end
        @(posedge clk); #1;
      end
      chk("max done seen", 32'(got_done), 32'd1);
      chk("max beat count", 32'(beats), 32'd256);
      chk("max data order", 32'(order_bad), 32'd0);
      chk("max wready while full", 32'(full_bad), 32'd0);
      chk("max done_err", 32'(got_err), 32'd0);
      bus.s_axi_wvalid = 1'b0; bus.fifo_wr_full = 1'b0; bus.done_ready = 1'b1;
      @(posedge clk); #1;
      bus.done_ready = 1'b0;
      #4;
      chk("max back to idle", 32'(bus.cmd_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbmc_wdata_ctrl.md
# hbmc_wdata_ctrl

Write-data sequencer between the AXI4 W channel and the downstream data FIFO of the HyperBus memory controller. Accepts one write command at a time from the AW decode stage, moves exactly `cmd_len + 1` W beats into the FIFO, and pauses the W channel while the FIFO is full. Checks WLAST framing against the beat counter and reports per-burst completion with an error flag to the B-response logic. Lives entirely in the AXI clock domain; the FIFO handles the crossing to the memory clock.

## Interface
Parameters:
- `DATA_WIDTH`, 32: AXI data width; legal values are 16, 32 and 64.
- `LEN_WIDTH`, 8: width of `cmd_len` (AXI4 AWLEN).

Ports:
- `s_axi_aclk`  in  1  single clock for all logic.
- `s_axi_aresetn`  in  1  synchronous reset, active-low.
- `cmd_valid`  in  1  write command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_len`  in  LEN_WIDTH  beats minus 1.
- `s_axi_wdata`  in  DATA_WIDTH  write data.
- `s_axi_wstrb`  in  DATA_WIDTH/8  byte strobes.
- `s_axi_wlast`  in  1  last-beat marker from the master.
- `s_axi_wvalid`  in  1  W beat valid.
- `s_axi_wready`  out  1  W beat accepted.
- `fifo_wr_din`  out  DATA_WIDTH  data to the FIFO.
- `fifo_wr_strb`  out  DATA_WIDTH/8  strobes to the FIFO.
- `fifo_wr_ena`  out  1  FIFO write enable.
- `fifo_wr_full`  in  1  FIFO full.
- `done_valid`  out  1  burst complete.
- `done_ready`  in  1  completion consumed.
- `done_err`  out  1  WLAST framing error for this burst; valid while `done_valid` is high.
- `busy`  out  1  high in the DATA and RESP states.

## Operation
- FSM with three states:
  - IDLE: `cmd_ready` = 1. On `cmd_valid & cmd_ready`, load `remaining` = `cmd_len`, clear `err`, and go to DATA.
  - DATA: `s_axi_wready` = `~fifo_wr_full`. A beat is a cycle with `s_axi_wvalid & s_axi_wready`.
    - On each beat, `fifo_wr_ena` = 1 and `fifo_wr_din`/`fifo_wr_strb` carry `s_axi_wdata`/`s_axi_wstrb` combinationally, in the same cycle.
    - On each beat with `remaining != 0`: decrement `remaining`. If `s_axi_wlast` = 1, set `err`.
    - On the beat with `remaining == 0`: if `s_axi_wlast` = 0, set `err`, then go to RESP.
  - RESP: `done_valid` = 1 and `done_err` = `err`. On `done_ready`, go to IDLE.
- The burst length is governed by the counter only. WLAST never ends or extends a burst.
- `cmd_ready` is 0 outside IDLE, so commands never overlap.
- `s_axi_wready` is 0 outside DATA.
- `fifo_wr_ena` is never high without a W handshake, so it is never high while `fifo_wr_full` = 1.
- Outside a beat, `fifo_wr_din`/`fifo_wr_strb` pass `s_axi_wdata`/`s_axi_wstrb` through; they are don't-care because `fifo_wr_ena` is 0.
- `remaining` is an unsigned LEN_WIDTH counter and never wraps: it is only decremented when non-zero.
- `cmd_len` = 0 is a single-beat burst. `cmd_len` = 2^LEN_WIDTH−1 gives 2^LEN_WIDTH beats.
- Any other `DATA_WIDTH` value must fail elaboration.

## Timing
- Reset: `s_axi_aresetn` sampled low at a clock edge puts the FSM in IDLE and clears `remaining` and `err`.
  - While reset is low, all outputs are gated to 0, including `cmd_ready`.
  - `cmd_ready` = 1 in the first cycle after the reset-release edge.
- Reset mid-burst: the block returns to IDLE and no completion is issued.
  - Beats already written stay in the FIFO. Flushing them is the FIFO reset's responsibility, not this block's.
- Command acceptance to first possible beat: 1 cycle. The command handshake happens in cycle N; `s_axi_wready` can first be high in cycle N+1.
- Throughput: 1 beat per cycle while the FIFO is not full.
- `fifo_wr_full` rising in cycle N drops `s_axi_wready` in cycle N, with no skid buffer. Full falling restores `s_axi_wready` in the same cycle.
- Last beat to completion: the last beat is in cycle N and `done_valid` rises in cycle N+1.
- `done_ready` held high gives a 1-cycle RESP state, and `cmd_ready` is high in the next cycle.
- Minimum command-to-command period is `cmd_len + 3` cycles.

## Test plan
- Single beat: `DATA_WIDTH` = 32, `cmd_len` = 0, one W beat (0xDEADBEEF, strb 0xF, wlast = 1) -> exactly one `fifo_wr_ena` pulse carrying 0xDEADBEEF/0xF; next cycle `done_valid` = 1 with `done_err` = 0; `cmd_ready` returns after `done_ready`.
- Full stall: `cmd_len` = 3, data 0..3, `fifo_wr_full` forced high in cycles 2–4 of DATA -> `s_axi_wready` = 0 in those cycles; the FIFO receives 0,1,2,3 in order with no duplicates or drops; `done_err` = 0.
- Early WLAST: `cmd_len` = 3 with wlast = 1 on beat 1 -> all 4 beats are still accepted and written; `done_err` = 1.
- Missing WLAST: `cmd_len` = 1 with wlast = 0 on both beats -> 2 beats are written and the FSM enters RESP; `done_err` = 1; a following clean burst reports `done_err` = 0.
- Completion backpressure: `done_ready` held low for 5 cycles -> `done_valid` stays high; `cmd_ready` = 0 and `s_axi_wready` = 0 throughout; a new `cmd_valid` is held off.
- Reset mid-burst: `cmd_len` = 7, reset asserted after beat 3 -> all outputs are 0 during reset; no `done_valid` is issued; `cmd_ready` = 1 one cycle after release; a new `cmd_len` = 0 burst completes normally.
